isdu_mw: RTL and testbench

ISDU_MW -- requirements
Module: isdu_mw

---
 rtl/isdu_pkg.sv | 50 +++++
 rtl/isdu_wait_ctr.sv | 33 +++
 rtl/isdu_mw.sv | 162 ++++++++++++++++
 tb/tb_isdu_mw.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isdu_pkg.sv
// isdu_pkg: state encoding, opcode values and datapath select codes shared
// by the ISDU control unit and its wait counter.
package isdu_pkg;

  typedef enum logic [5:0] {
    S_HALTED, S_FETCH_MAR, S_FETCH_RD, S_FETCH_IR, S_DECODE,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_TAKE, S_JMP, S_JSR_R7, S_JSR_PC,
    S_LD_ADDR, S_LDR_ADDR, S_LD_RD, S_LD_DONE,
    S_LDI_ADDR, S_LDI_RD1, S_LDI_MAR, S_LDI_RD2, S_LEA,
    S_ST_ADDR, S_STR_ADDR, S_ST_DATA, S_ST_WR,
    S_STI_ADDR, S_STI_RD, S_STI_MAR, S_STI_DATA, S_STI_WR,
    S_PAUSE_WAIT, S_PAUSE_REL
  } state_e;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_LD    = 4'b0010;
  localparam logic [3:0] OP_ST    = 4'b0011;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_LDI   = 4'b1010;
  localparam logic [3:0] OP_STI   = 4'b1011;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;
  localparam logic [3:0] OP_LEA   = 4'b1110;

  localparam logic [1:0] PCMUX_INC   = 2'b00;
  localparam logic [1:0] PCMUX_ADDER = 2'b01;
  localparam logic [1:0] DRMUX_IR    = 2'b00;
  localparam logic [1:0] DRMUX_R7    = 2'b10;
  localparam logic [1:0] SR1MUX_HI   = 2'b00;  // IR[11:9]
  localparam logic [1:0] SR1MUX_LO   = 2'b01;  // IR[8:6]
  localparam logic [1:0] A2_ZERO     = 2'b00;
  localparam logic [1:0] A2_OFF9     = 2'b01;
  localparam logic [1:0] A2_OFF6     = 2'b10;
  localparam logic [1:0] A2_OFF11    = 2'b11;
  localparam logic [1:0] ALUK_ADD    = 2'b00;
  localparam logic [1:0] ALUK_AND    = 2'b01;
  localparam logic [1:0] ALUK_NOT    = 2'b10;
  localparam logic [1:0] ALUK_PASS   = 2'b11;

  function automatic logic is_access(state_e s);
    return s inside {S_FETCH_RD, S_LD_RD, S_LDI_RD1, S_LDI_RD2, S_STI_RD,
                     S_ST_WR, S_STI_WR};
  endfunction

endpackage

// File: rtl/isdu_wait_ctr.sv
// isdu_wait_ctr: memory wait-state counter; loads on access entry,
// counts down each access cycle, done when it reaches zero.
module isdu_wait_ctr #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             done_o
);

  logic [WIDTH-1:0] count_q, count_d;

  // next count: load has priority over decrement, never wraps below zero
  always_comb begin
    count_d = count_q;
    if (load_i)
      count_d = load_val_i;
    else if (dec_i && (count_q != '0))
      count_d = count_q - 1'b1;
  end

  // counter register with synchronous clear
  always_ff @(posedge clk_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/isdu_mw.sv
// isdu_mw: LC-3 style instruction sequencing/decode unit with
// parameterised SRAM wait states. Define ISDU_PAUSE_EN to enable the
// PAUSE (1101) instruction; otherwise 1101 is an unsupported opcode.
module isdu_mw
  import isdu_pkg::*;
#(
  parameter int unsigned MEM_WAIT        = 2,
  parameter int unsigned HALT_ON_ILLEGAL = 0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
  output logic       GatePC, GateMDR, GateALU, GateMARMUX,
  output logic [1:0] PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK,
  output logic       SR2MUX, ADDR1MUX, MARMUX,
  output logic       Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE,
  output logic       Busy
);

  localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);
  localparam state_e     ILLEGAL_NEXT = (HALT_ON_ILLEGAL != 0) ? S_HALTED : S_FETCH_MAR;

  state_e state_q, state_d;
  logic   wait_done;

  // Counter loads while moving into an access state; access states are
  // never adjacent, so "next is access, current is not" marks entry.
  isdu_wait_ctr #(.WIDTH(4)) u_wait (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .load_i     (is_access(state_d) && !is_access(state_q)),
    .load_val_i (WAIT_LOAD),
    .dec_i      (is_access(state_q) && !wait_done),
    .done_o     (wait_done)
  );

  // next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HALTED:    if (Run) state_d = S_FETCH_MAR;
      S_FETCH_MAR: state_d = S_FETCH_RD;
      S_FETCH_RD:  if (wait_done) state_d = S_FETCH_IR;
      S_FETCH_IR:  state_d = S_DECODE;
      S_DECODE: begin
        case (Opcode)
          OP_ADD:   state_d = S_ADD;
          OP_AND:   state_d = S_AND;
          OP_NOT:   state_d = S_NOT;
          OP_BR:    state_d = S_BR;
          OP_JMP:   state_d = S_JMP;
          OP_JSR:   state_d = S_JSR_R7;
          OP_LD:    state_d = S_LD_ADDR;
          OP_LDR:   state_d = S_LDR_ADDR;
          OP_LDI:   state_d = S_LDI_ADDR;
          OP_LEA:   state_d = S_LEA;
          OP_ST:    state_d = S_ST_ADDR;
          OP_STR:   state_d = S_STR_ADDR;
          OP_STI:   state_d = S_STI_ADDR;
`ifdef ISDU_PAUSE_EN
          OP_PAUSE: state_d = S_PAUSE_WAIT;
`else
          OP_PAUSE: state_d = ILLEGAL_NEXT;
`endif
          default:  state_d = ILLEGAL_NEXT;
        endcase
      end
      S_BR:         state_d = BEN ? S_BR_TAKE : S_FETCH_MAR;
      S_JSR_R7:     state_d = S_JSR_PC;
      S_LD_ADDR,
      S_LDR_ADDR:   state_d = S_LD_RD;
      S_LD_RD:      if (wait_done) state_d = S_LD_DONE;
      S_LDI_ADDR:   state_d = S_LDI_RD1;
      S_LDI_RD1:    if (wait_done) state_d = S_LDI_MAR;
      S_LDI_MAR:    state_d = S_LDI_RD2;
      S_LDI_RD2:    if (wait_done) state_d = S_LD_DONE;
      S_ST_ADDR,
      S_STR_ADDR:   state_d = S_ST_DATA;
      S_ST_DATA:    state_d = S_ST_WR;
      S_ST_WR:      if (wait_done) state_d = S_FETCH_MAR;
      S_STI_ADDR:   state_d = S_STI_RD;
      S_STI_RD:     if (wait_done) state_d = S_STI_MAR;
      S_STI_MAR:    state_d = S_STI_DATA;
      S_STI_DATA:   state_d = S_STI_WR;
      S_STI_WR:     if (wait_done) state_d = S_FETCH_MAR;
      S_PAUSE_WAIT: if (Continue) state_d = S_PAUSE_REL;
      S_PAUSE_REL:  if (!Continue) state_d = S_FETCH_MAR;
      S_ADD, S_AND, S_NOT, S_BR_TAKE, S_JMP, S_JSR_PC,
      S_LD_DONE, S_LEA: state_d = S_FETCH_MAR;
      default:      state_d = S_HALTED;
    endcase
  end

  // state register; reset wins over any state, including mid-access
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= S_HALTED;
    else       state_q <= state_d;
  end

  // Moore control word decoded from the registered state
  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_INC; DRMUX = DRMUX_IR; SR1MUX = SR1MUX_HI;
    ADDR2MUX = A2_ZERO; ALUK = ALUK_ADD;
    SR2MUX = 1'b0; ADDR1MUX = 1'b0; MARMUX = 1'b0;
    Mem_OE = 1'b1; Mem_WE = 1'b1;
    case (state_q)
      S_FETCH_MAR: begin GatePC = 1'b1; LD_MAR = 1'b1; LD_PC = 1'b1; PCMUX = PCMUX_INC; end
      S_FETCH_RD, S_LD_RD, S_LDI_RD1, S_LDI_RD2, S_STI_RD: begin
        Mem_OE = 1'b0;
        LD_MDR = wait_done;
      end
      S_ST_WR, S_STI_WR: begin Mem_WE = 1'b0; GateMDR = 1'b1; end
      S_FETCH_IR:  begin GateMDR = 1'b1; LD_IR = 1'b1; end
      S_DECODE:    LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        SR1MUX = SR1MUX_LO; SR2MUX = ~IR_5;
        ALUK = (state_q == S_ADD) ? ALUK_ADD : (state_q == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S_BR_TAKE: begin ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_JMP:     begin SR1MUX = SR1MUX_LO; PCMUX = PCMUX_ADDER; LD_PC = 1'b1; end
      S_JSR_R7:  begin DRMUX = DRMUX_R7; GatePC = 1'b1; LD_REG = 1'b1; end
      S_JSR_PC: begin
        PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
        ADDR1MUX = IR_11;
        ADDR2MUX = IR_11 ? A2_OFF11 : A2_ZERO;
      end
      S_LD_ADDR, S_LDI_ADDR, S_ST_ADDR, S_STI_ADDR: begin
        GateMARMUX = 1'b1; MARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF9; LD_MAR = 1'b1;
      end
      S_LDR_ADDR, S_STR_ADDR: begin
        GateMARMUX = 1'b1; MARMUX = 1'b1; SR1MUX = SR1MUX_LO; ADDR2MUX = A2_OFF6; LD_MAR = 1'b1;
      end
      S_LDI_MAR, S_STI_MAR: begin GateMDR = 1'b1; LD_MAR = 1'b1; end
      S_LD_DONE: begin GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; DRMUX = DRMUX_IR; end
      S_LEA: begin
        GateMARMUX = 1'b1; MARMUX = 1'b1; ADDR1MUX = 1'b1; ADDR2MUX = A2_OFF9;
        LD_REG = 1'b1; LD_CC = 1'b1;
      end
      S_ST_DATA, S_STI_DATA: begin
        SR1MUX = SR1MUX_HI; ALUK = ALUK_PASS; GateALU = 1'b1; LD_MDR = 1'b1;
      end
      S_PAUSE_WAIT, S_PAUSE_REL: LD_LED = 1'b1;
      default: ;
    endcase
  end

  assign Mem_CE = 1'b0;
  assign Mem_UB = 1'b0;
  assign Mem_LB = 1'b0;
  assign Busy   = !((state_q == S_HALTED) || (state_q == S_PAUSE_WAIT));

endmodule

// File: tb/tb_isdu_mw.sv
// tb_isdu_mw: directed-vector bench for isdu_mw. Instance A uses
// MEM_WAIT=3/HALT_ON_ILLEGAL=1, instance B MEM_WAIT=1/HALT_ON_ILLEGAL=0.
// Each DUT's outputs are packed into one 31-bit control word.
module tb_isdu_mw;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic       rst_a = 1'b1, rst_b = 1'b1, run_a = 1'b0, run_b = 1'b0;
  logic       cont = 1'b0, ir5 = 1'b0, ir11 = 1'b0, ben = 1'b0;
  logic [3:0] opcode = 4'b0000;
  wire  [30:0] ctl_a, ctl_b;

  int checks = 0;
  int failures = 0;

  // control word bit positions
  localparam logic [30:0] B_LDMAR  = 31'd1 << 30, B_LDMDR = 31'd1 << 29, B_LDIR  = 31'd1 << 28;
  localparam logic [30:0] B_LDBEN  = 31'd1 << 27, B_LDCC  = 31'd1 << 26, B_LDREG = 31'd1 << 25;
  localparam logic [30:0] B_LDPC   = 31'd1 << 24, B_LDLED = 31'd1 << 23, B_GPC   = 31'd1 << 22;
  localparam logic [30:0] B_GMDR   = 31'd1 << 21, B_GALU  = 31'd1 << 20, B_GMARM = 31'd1 << 19;
  localparam logic [30:0] F_PC_ADD = 31'd1 << 17;   // PCMUX  = 01
  localparam logic [30:0] F_DR_R7  = 31'd1 << 16;   // DRMUX  = 10
  localparam logic [30:0] F_SR1_LO = 31'd1 << 13;   // SR1MUX = 01
  localparam logic [30:0] F_A2_9   = 31'd1 << 11;   // ADDR2MUX = 01
  localparam logic [30:0] F_A2_11  = 31'd3 << 11;   // ADDR2MUX = 11
  localparam logic [30:0] F_K_AND  = 31'd1 << 9;    // ALUK = 01
  localparam logic [30:0] F_K_NOT  = 31'd1 << 10;   // ALUK = 10
  localparam logic [30:0] F_K_PASS = 31'd3 << 9;    // ALUK = 11
  localparam logic [30:0] B_SR2    = 31'd1 << 8, B_A1 = 31'd1 << 7, B_MARMUX = 31'd1 << 6;
  localparam logic [30:0] B_OE     = 31'd1 << 2, B_WE = 31'd1 << 1, B_BUSY = 31'd1;

  // expected words per state
  localparam logic [30:0] E_HALT   = B_OE | B_WE;
  localparam logic [30:0] RUNW     = B_OE | B_WE | B_BUSY;
  localparam logic [30:0] E_FMAR   = RUNW | B_GPC | B_LDMAR | B_LDPC;
  localparam logic [30:0] E_RD     = B_WE | B_BUSY;
  localparam logic [30:0] E_RDL    = E_RD | B_LDMDR;
  localparam logic [30:0] E_FIR    = RUNW | B_GMDR | B_LDIR;
  localparam logic [30:0] E_DEC    = RUNW | B_LDBEN;
  localparam logic [30:0] E_ALU    = RUNW | B_GALU | B_LDREG | B_LDCC | F_SR1_LO;
  localparam logic [30:0] E_BRTK   = RUNW | B_A1 | F_A2_9 | F_PC_ADD | B_LDPC;
  localparam logic [30:0] E_JSR7   = RUNW | F_DR_R7 | B_GPC | B_LDREG;
  localparam logic [30:0] E_JSRR   = RUNW | F_PC_ADD | B_LDPC;
  localparam logic [30:0] E_JSR11  = RUNW | F_PC_ADD | B_LDPC | B_A1 | F_A2_11;
  localparam logic [30:0] E_M2MAR  = RUNW | B_GMDR | B_LDMAR;
  localparam logic [30:0] E_STDAT  = RUNW | F_K_PASS | B_GALU | B_LDMDR;
  localparam logic [30:0] E_WR     = B_OE | B_BUSY | B_GMDR;
  localparam logic [30:0] E_LDDONE = RUNW | B_GMDR | B_LDREG | B_LDCC;
  localparam logic [30:0] E_LEA    = RUNW | B_GMARM | B_MARMUX | B_A1 | F_A2_9 | B_LDREG | B_LDCC;
  // address-calculation cycle: only "no memory access, no PC/reg write, busy" is checked
  localparam logic [30:0] ANY      = '1;
  localparam logic [30:0] M_ADDR   = B_OE | B_WE | B_BUSY | B_LDREG | B_LDPC;

  isdu_mw #(.MEM_WAIT(3), .HALT_ON_ILLEGAL(1)) dut_a (
    .Clk(Clk), .Reset(rst_a), .Run(run_a), .Continue(cont), .Opcode(opcode),
    .IR_5(ir5), .IR_11(ir11), .BEN(ben),
    .LD_MAR(ctl_a[30]), .LD_MDR(ctl_a[29]), .LD_IR(ctl_a[28]), .LD_BEN(ctl_a[27]),
    .LD_CC(ctl_a[26]), .LD_REG(ctl_a[25]), .LD_PC(ctl_a[24]), .LD_LED(ctl_a[23]),
    .GatePC(ctl_a[22]), .GateMDR(ctl_a[21]), .GateALU(ctl_a[20]), .GateMARMUX(ctl_a[19]),
    .PCMUX(ctl_a[18:17]), .DRMUX(ctl_a[16:15]), .SR1MUX(ctl_a[14:13]),
    .ADDR2MUX(ctl_a[12:11]), .ALUK(ctl_a[10:9]),
    .SR2MUX(ctl_a[8]), .ADDR1MUX(ctl_a[7]), .MARMUX(ctl_a[6]),
    .Mem_CE(ctl_a[5]), .Mem_UB(ctl_a[4]), .Mem_LB(ctl_a[3]), .Mem_OE(ctl_a[2]),
    .Mem_WE(ctl_a[1]), .Busy(ctl_a[0])
  );

  isdu_mw #(.MEM_WAIT(1), .HALT_ON_ILLEGAL(0)) dut_b (
    .Clk(Clk), .Reset(rst_b), .Run(run_b), .Continue(cont), .Opcode(opcode),
    .IR_5(ir5), .IR_11(ir11), .BEN(ben),
    .LD_MAR(ctl_b[30]), .LD_MDR(ctl_b[29]), .LD_IR(ctl_b[28]), .LD_BEN(ctl_b[27]),
    .LD_CC(ctl_b[26]), .LD_REG(ctl_b[25]), .LD_PC(ctl_b[24]), .LD_LED(ctl_b[23]),
    .GatePC(ctl_b[22]), .GateMDR(ctl_b[21]), .GateALU(ctl_b[20]), .GateMARMUX(ctl_b[19]),
    .PCMUX(ctl_b[18:17]), .DRMUX(ctl_b[16:15]), .SR1MUX(ctl_b[14:13]),
    .ADDR2MUX(ctl_b[12:11]), .ALUK(ctl_b[10:9]),
    .SR2MUX(ctl_b[8]), .ADDR1MUX(ctl_b[7]), .MARMUX(ctl_b[6]),
    .Mem_CE(ctl_b[5]), .Mem_UB(ctl_b[4]), .Mem_LB(ctl_b[3]), .Mem_OE(ctl_b[2]),
    .Mem_WE(ctl_b[1]), .Busy(ctl_b[0])
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // reset one instance, then pulse (or hold) Run; returns in FETCH_MAR
  task automatic start(input bit sel_b, input bit hold_run);
    if (sel_b) begin
      rst_b = 1'b1; run_b = 1'b0; tick();
      rst_b = 1'b0; run_b = 1'b1; tick();
      run_b = hold_run;
    end else begin
      rst_a = 1'b1; run_a = 1'b0; tick();
      rst_a = 1'b0; run_a = 1'b1; tick();
      run_a = hold_run;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; run_a = 1'b0; run_b = 1'b0;
    tick();
    checks++;
    if (ctl_a !== E_HALT) begin failures++; $display("FAIL reset_a: got %h expected %h", ctl_a, E_HALT); end
    checks++;
    if (ctl_b !== E_HALT) begin failures++; $display("FAIL reset_b: got %h expected %h", ctl_b, E_HALT); end
    rst_a = 1'b0;
    tick(); tick();
    checks++;
    if (ctl_a !== E_HALT) begin failures++; $display("FAIL idle_no_run: got %h expected %h", ctl_a, E_HALT); end
  endtask

  // ADD / AND / NOT, MEM_WAIT=3: three OE-low fetch cycles, FETCH_MAR recurs 7 edges later
  task automatic test_alu();
    logic [30:0] exp_q[$];
    logic [30:0] ex;
    string nm;
    for (int t = 0; t < 3; t++) begin
      case (t)
        0:       begin opcode = 4'b0001; ir5 = 1'b1; ex = E_ALU;                    nm = "add"; end
        1:       begin opcode = 4'b0101; ir5 = 1'b0; ex = E_ALU | B_SR2 | F_K_AND;  nm = "and"; end
        default: begin opcode = 4'b1001; ir5 = 1'b1; ex = E_ALU | F_K_NOT;          nm = "not"; end
      endcase
      exp_q = '{E_FMAR, E_RD, E_RD, E_RDL, E_FIR, E_DEC, ex, E_FMAR};
      start(1'b0, 1'b0);
      foreach (exp_q[i]) begin
        if (i != 0) tick();
        checks++;
        if (ctl_a !== exp_q[i]) begin
          failures++;
          $display("FAIL %s step %0d: got %h expected %h", nm, i, ctl_a, exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_br();
    logic [30:0] exp_q[$];
    for (int t = 0; t < 2; t++) begin
      opcode = 4'b0000; ben = (t == 1);
      if (t == 0) exp_q = '{E_DEC, RUNW, E_FMAR};
      else        exp_q = '{E_DEC, RUNW, E_BRTK, E_FMAR};
      start(1'b0, 1'b0);
      repeat (5) tick();
      foreach (exp_q[i]) begin
        if (i != 0) tick();
        checks++;
        if (ctl_a !== exp_q[i]) begin
          failures++;
          $display("FAIL br_ben%0d step %0d: got %h expected %h", t, i, ctl_a, exp_q[i]);
        end
      end
    end
    ben = 1'b0;
  endtask

  task automatic test_jsr();
    logic [30:0] exp_q[$];
    for (int t = 0; t < 2; t++) begin
      opcode = 4'b0100; ir11 = (t == 1);
      exp_q = '{E_DEC, E_JSR7, (t == 1) ? E_JSR11 : E_JSRR, E_FMAR};
      start(1'b0, 1'b0);
      repeat (5) tick();
      foreach (exp_q[i]) begin
        if (i != 0) tick();
        checks++;
        if (ctl_a !== exp_q[i]) begin
          failures++;
          $display("FAIL jsr_ir11_%0d step %0d: got %h expected %h", t, i, ctl_a, exp_q[i]);
        end
      end
    end
    ir11 = 1'b0;
  endtask

  // reset during the second LD_RD wait cycle aborts the access
  task automatic test_ld_reset();
    logic [30:0] exp_q[$];
    logic [30:0] got, want;
    opcode = 4'b0010;
    exp_q = '{E_DEC, ANY, E_RD, E_RD};
    start(1'b0, 1'b0);
    repeat (5) tick();
    foreach (exp_q[i]) begin
      if (i != 0) tick();
      got  = (exp_q[i] == ANY) ? (ctl_a & M_ADDR) : ctl_a;
      want = (exp_q[i] == ANY) ? (RUNW & M_ADDR) : exp_q[i];
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL ld_rd step %0d: got %h expected %h", i, got, want);
      end
    end
    rst_a = 1'b1;
    tick();
    checks++;
    if (ctl_a !== E_HALT) begin failures++; $display("FAIL ld_abort: got %h expected %h", ctl_a, E_HALT); end
    rst_a = 1'b0;
    tick();
    checks++;
    if (ctl_a !== E_HALT) begin failures++; $display("FAIL ld_abort_hold: got %h expected %h", ctl_a, E_HALT); end
  endtask

  task automatic test_illegal_a();
    opcode = 4'b1111;
    start(1'b0, 1'b0);
    repeat (5) tick();
    checks++;
    if (ctl_a !== E_DEC) begin failures++; $display("FAIL illegal_dec: got %h expected %h", ctl_a, E_DEC); end
    tick();
    checks++;
    if (ctl_a !== E_HALT) begin failures++; $display("FAIL illegal_halt: got %h expected %h", ctl_a, E_HALT); end
  endtask

  task automatic test_pause();
    opcode = 4'b1101; cont = 1'b0;
    start(1'b0, 1'b0);
    repeat (6) tick();
`ifdef ISDU_PAUSE_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctl_a !== (E_HALT | B_LDLED)) begin
        failures++; $display("FAIL pause_wait %0d: got %h expected %h", i, ctl_a, E_HALT | B_LDLED);
      end
      if (i < 2) tick();
    end
    cont = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (ctl_a !== (RUNW | B_LDLED)) begin
        failures++; $display("FAIL pause_rel %0d: got %h expected %h", i, ctl_a, RUNW | B_LDLED);
      end
    end
    cont = 1'b0;
    tick();
    checks++;
    if (ctl_a !== E_FMAR) begin failures++; $display("FAIL pause_exit: got %h expected %h", ctl_a, E_FMAR); end
`else
    checks++;
    if (ctl_a !== E_HALT) begin failures++; $display("FAIL pause_illegal: got %h expected %h", ctl_a, E_HALT); end
`endif
  endtask

  // STI with MEM_WAIT=1: one OE-low address read, one WE-low write
  task automatic test_sti();
    logic [30:0] exp_q[$];
    logic [30:0] got, want;
    rst_a = 1'b1;
    opcode = 4'b1011;
    exp_q = '{E_FMAR, E_RDL, E_FIR, E_DEC, ANY, E_RDL, E_M2MAR, E_STDAT, E_WR, E_FMAR};
    start(1'b1, 1'b0);
    foreach (exp_q[i]) begin
      if (i != 0) tick();
      got  = (exp_q[i] == ANY) ? (ctl_b & M_ADDR) : ctl_b;
      want = (exp_q[i] == ANY) ? (RUNW & M_ADDR) : exp_q[i];
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL sti step %0d: got %h expected %h", i, got, want);
      end
    end
  endtask

  task automatic test_ld_lea_b();
    logic [30:0] exp_q[$];
    logic [30:0] got, want;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) begin opcode = 4'b0010; exp_q = '{E_DEC, ANY, E_RDL, E_LDDONE, E_FMAR}; end
      else        begin opcode = 4'b1110; exp_q = '{E_DEC, E_LEA, E_FMAR}; end
      start(1'b1, 1'b0);
      repeat (3) tick();
      foreach (exp_q[i]) begin
        if (i != 0) tick();
        got  = (exp_q[i] == ANY) ? (ctl_b & M_ADDR) : ctl_b;
        want = (exp_q[i] == ANY) ? (RUNW & M_ADDR) : exp_q[i];
        checks++;
        if (got !== want) begin
          failures++;
          $display("FAIL %s step %0d: got %h expected %h", (t == 0) ? "ld" : "lea", i, got, want);
        end
      end
    end
  endtask

  // unsupported opcode with HALT_ON_ILLEGAL=0 refetches; Run held high is ignored
  task automatic test_illegal_b();
    logic [30:0] exp_q[$];
    opcode = 4'b1000;
    exp_q = '{E_DEC, E_FMAR, E_RDL, E_FIR};
    start(1'b1, 1'b1);
    repeat (3) tick();
    foreach (exp_q[i]) begin
      if (i != 0) tick();
      checks++;
      if (ctl_b !== exp_q[i]) begin
        failures++;
        $display("FAIL illegal_b step %0d: got %h expected %h", i, ctl_b, exp_q[i]);
      end
    end
    run_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_br();
    test_jsr();
    test_ld_reset();
    test_illegal_a();
    test_pause();
    test_sti();
    test_ld_lea_b();
    test_illegal_b();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
